// File: rtl/tetron_piece_controller.sv
// rtl/tetron_piece_controller.sv - falling-piece sequencer: spawn, move/rotate/drop queries, lock, game over
//
// Optional feature macro: TETRON_HARD_DROP_EN (adds input hard_drop; repeated drop checks until landing)
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   start                          begin a game from IDLE or GAMEOVER
//   piece_type[2:0]                next piece (0..6 = I,O,T,S,Z,J,L; 7 treated as O)
//   move_left/move_right/rotate/drop_tick   single-cycle player/gravity requests
//   hard_drop                      (TETRON_HARD_DROP_EN only) drop until landed
//   shaper_active[6:0]             one-hot shaper enable
//   tetron_rotation[2:0]           candidate rotation to all shapers
//   cand_h/cand_v[4:0]             candidate position for the collision checker
//   piece_h/piece_v[4:0], piece_rot[2:0]   committed placement
//   chk_req / chk_ack / chk_collide        collision query handshake
//   lock_valid / lock_ack          landed-piece handoff to the board
//   busy                           high in every state except READY
//   game_over                      sticky game-over flag
module tetron_piece_controller #(
    parameter int BOARD_W = 10,
    parameter int SPAWN_H = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] piece_type,
    input  logic       move_left,
    input  logic       move_right,
    input  logic       rotate,
    input  logic       drop_tick,
`ifdef TETRON_HARD_DROP_EN
    input  logic       hard_drop,
`endif
    output logic [6:0] shaper_active,
    output logic [2:0] tetron_rotation,
    output logic [4:0] cand_h,
    output logic [4:0] cand_v,
    output logic [4:0] piece_h,
    output logic [4:0] piece_v,
    output logic [2:0] piece_rot,
    output logic       chk_req,
    input  logic       chk_ack,
    input  logic       chk_collide,
    output logic       lock_valid,
    input  logic       lock_ack,
    output logic       busy,
    output logic       game_over
);

    // Keep the spawn column on the board even if the parameters disagree.
    localparam logic [4:0] SPAWN_COL = (SPAWN_H < BOARD_W) ? 5'(SPAWN_H) : 5'd0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SPAWN,
        S_SETTLE,
        S_CHECK,
        S_READY,
        S_LOCK,
        S_GAMEOVER
    } state_t;

    // What the pending query is for; decides the collision outcome.
    typedef enum logic [1:0] {
        K_SPAWN,
        K_DROP,
        K_MOVE
    } kind_t;

    state_t     state;
    kind_t      kind;
    logic [2:0] cand_rot;
    logic       reverting;   // SETTLE after a revert returns to READY without a query
    logic       hd_loop;     // hard drop in progress
    logic       hd_req;

    always_comb begin
`ifdef TETRON_HARD_DROP_EN
        hd_req = hard_drop;
`else
        hd_req = 1'b0;
`endif
    end

    assign tetron_rotation = cand_rot;

    function automatic logic [6:0] type_onehot(input logic [2:0] t);
        logic [2:0] idx;
        idx = (t == 3'd7) ? 3'd1 : t;
        return 7'b000_0001 << idx;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            kind          <= K_SPAWN;
            reverting     <= 1'b0;
            hd_loop       <= 1'b0;
            shaper_active <= 7'd0;
            cand_rot      <= 3'd0;
            cand_h        <= 5'd0;
            cand_v        <= 5'd0;
            piece_h       <= 5'd0;
            piece_v       <= 5'd0;
            piece_rot     <= 3'd0;
            chk_req       <= 1'b0;
            lock_valid    <= 1'b0;
            busy          <= 1'b1;
            game_over     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_SPAWN;
                    end
                end

                S_SPAWN: begin
                    shaper_active <= type_onehot(piece_type);
                    cand_h        <= SPAWN_COL;
                    cand_v        <= 5'd0;
                    cand_rot      <= 3'd0;
                    kind          <= K_SPAWN;
                    reverting     <= 1'b0;
                    hd_loop       <= 1'b0;
                    state         <= S_SETTLE;
                end

                S_SETTLE: begin
                    if (reverting) begin
                        reverting <= 1'b0;
                        busy      <= 1'b0;
                        state     <= S_READY;
                    end else begin
                        chk_req <= 1'b1;
                        state   <= S_CHECK;
                    end
                end

                S_CHECK: begin
                    if (chk_ack) begin
                        chk_req <= 1'b0;
                        if (!chk_collide) begin
                            piece_h   <= cand_h;
                            piece_v   <= cand_v;
                            piece_rot <= cand_rot;
                            if (hd_loop) begin
                                // Keep falling: next row goes straight to another query.
                                cand_v <= cand_v + 5'd1;
                                state  <= S_SETTLE;
                            end else begin
                                busy  <= 1'b0;
                                state <= S_READY;
                            end
                        end else begin
                            case (kind)
                                K_SPAWN: begin
                                    game_over     <= 1'b1;
                                    shaper_active <= 7'd0;
                                    state         <= S_GAMEOVER;
                                end
                                K_DROP: begin
                                    hd_loop    <= 1'b0;
                                    lock_valid <= 1'b1;
                                    state      <= S_LOCK;
                                end
                                default: begin
                                    cand_h    <= piece_h;
                                    cand_v    <= piece_v;
                                    cand_rot  <= piece_rot;
                                    reverting <= 1'b1;
                                    state     <= S_SETTLE;
                                end
                            endcase
                        end
                    end
                end

                S_READY: begin
                    // Candidate equals committed here; one request wins, the rest are dropped.
                    if (hd_req) begin
                        cand_v  <= cand_v + 5'd1;
                        kind    <= K_DROP;
                        hd_loop <= 1'b1;
                        busy    <= 1'b1;
                        state   <= S_SETTLE;
                    end else if (drop_tick) begin
                        cand_v <= cand_v + 5'd1;
                        kind   <= K_DROP;
                        busy   <= 1'b1;
                        state  <= S_SETTLE;
                    end else if (rotate) begin
                        cand_rot <= {1'b0, cand_rot[1:0] + 2'd1};
                        kind     <= K_MOVE;
                        busy     <= 1'b1;
                        state    <= S_SETTLE;
                    end else if (move_left) begin
                        // Left at column 0 is swallowed without a query.
                        if (cand_h != 5'd0) begin
                            cand_h <= cand_h - 5'd1;
                            kind   <= K_MOVE;
                            busy   <= 1'b1;
                            state  <= S_SETTLE;
                        end
                    end else if (move_right) begin
                        cand_h <= cand_h + 5'd1;
                        kind   <= K_MOVE;
                        busy   <= 1'b1;
                        state  <= S_SETTLE;
                    end
                end

                S_LOCK: begin
                    if (lock_ack) begin
                        lock_valid <= 1'b0;
                        state      <= S_SPAWN;
                    end
                end

                S_GAMEOVER: begin
                    if (start) begin
                        game_over <= 1'b0;
                        state     <= S_SPAWN;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
